instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Multi-cycle fetch/execute sequencer that owns the program counter and gates when the
//  decoded control word may take effect. Sits between instruction memory and the
//  controlUnit decode outputs. Adds stalls for IN/OUT handshakes, HLT with resume, and
//  branch/jump resolution. Emits a one-cycle commit strobe that qualifies every
//  architectural write: register file, data memory and IO.
// PARAMETERS
//  ADDR_WIDTH     10   width of pcAddress/mainAddress; PC wraps modulo 2^ADDR_WIDTH
//  RESET_ADDRESS  0    PC value loaded on reset
//  COUNT_WIDTH    32   width of retiredCount
// PORTS
//  clock         in   1            single clock, all state on rising edge
//  reset         in   1            synchronous, active-high
//  jump          in   1            decoded jmp
//  bzero         in   1            decoded branch-on-zero
//  bnegative     in   1            decoded branch-on-negative
//  HLT           in   1            decoded hlt
//  isIn          in   1            decoded IN opcode
//  isOut         in   1            decoded OUT opcode
//  zeroFlag      in   1            ALU zero flag of the current instruction
//  negativeFlag  in   1            ALU negative flag of the current instruction
//  mainAddress   in   ADDR_WIDTH   branch/jump target
//  inputValid    in   1            external input word ready (switches + enter)
//  outputAck     in   1            display accepted output word
//  resume        in   1            button; rising edge leaves HALTED
//  pcAddress     out  ADDR_WIDTH   instruction memory address (registered PC)
//  commit        out  1            write qualifier, high exactly one cycle per retired instr
//  inAck         out  1            input word consumed (equals commit of an IN)
//  outValid      out  1            output word presented to display
//  halted        out  1            high while in HALTED
//  retiredCount  out  COUNT_WIDTH  retired instructions, saturating
//  state         out  3            debug: FETCH=0 EXEC=1 WAIT_IN=2 WAIT_OUT=3 HALTED=4
// BEHAVIOUR
//  Reset: state=FETCH, PC=RESET_ADDRESS, retiredCount=0, resume edge register=0.
//   commit/inAck/outValid/halted are 0 during and after reset until a transition requires otherwise.
//  commit, inAck and outValid are combinational from state and inputs (Mealy). All are 0 in FETCH and HALTED.
//  FETCH: pcAddress presented; instruction memory is registered.
//   Always go to EXEC the next cycle. No commit.
//  EXEC: decode inputs valid. Priority order:
//   1. HLT: no commit; PC unchanged; -> HALTED.
//   2. isIn: if inputValid=1, commit=inAck=1 and go to FETCH. Otherwise go to WAIT_IN.
//   3. isOut: outValid=1. If outputAck=1, commit=1 and go to FETCH. Otherwise go to WAIT_OUT.
//   4. Otherwise: commit=1 and go to FETCH.
//  WAIT_IN: hold until inputValid=1; in that cycle commit=inAck=1 and go to FETCH.
//  WAIT_OUT: outValid held at 1; in the cycle outputAck=1, commit=1 and go to FETCH.
//  PC update happens only on a commit cycle:
//   jump=1 -> mainAddress
//   else (bzero&zeroFlag)|(bnegative&negativeFlag) -> mainAddress
//   else PC+1, with all-ones wrapping to 0.
//  HALTED: halted=1. When resume=1 and the previous-cycle resume=0: PC=PC+1 and go to FETCH.
//   A level-held resume does not re-trigger on a later HLT.
//   The resume edge register samples every cycle in all states.
//  retiredCount: +1 on each commit cycle; holds at all-ones. HLT is not counted.
//  Multiple decode flags asserted together are resolved by the priority above.
//   jump wins over a taken branch.
//  Throughput: 2 cycles per non-stalled instruction.
// TESTING
//  1. Reset, then 3 plain ops (no flags) -> pcAddress 0,0,1,1,2,2,3; commit on cycles 2,4,6; retiredCount=3.
//  2. PC=1023, plain op -> PC wraps to 0. PC=5 with jump=1, mainAddress=200 -> PC=200.
//     Same PC with bzero=1, zeroFlag=0 -> PC=6.
//  3. isIn with inputValid low 4 cycles then high -> state 2 held 4 cycles; a single commit+inAck pulse; PC+1.
//  4. isOut with outputAck on 3rd cycle -> outValid high 3 cycles; commit only in the ack cycle.
//  5. HLT at PC=10 with resume held high -> stays HALTED. resume low then high -> FETCH with PC=11; count unchanged.
//  6. reset asserted in WAIT_OUT -> next cycle state=FETCH, PC=0, outValid=0, retiredCount=0.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Fetch/execute sequencer: owns the PC, stalls on IN/OUT handshakes and HLT,
// and emits a one-cycle commit strobe that qualifies every architectural write.
module instruction_sequencer #(
    parameter int                    ADDR_WIDTH    = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = '0,
    parameter int                    COUNT_WIDTH   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   jump,
    input  logic                   bzero,
    input  logic                   bnegative,
    input  logic                   HLT,
    input  logic                   isIn,
    input  logic                   isOut,
    input  logic                   zeroFlag,
    input  logic                   negativeFlag,
    input  logic [ADDR_WIDTH-1:0]  mainAddress,
    input  logic                   inputValid,
    input  logic                   outputAck,
    input  logic                   resume,
    output logic [ADDR_WIDTH-1:0]  pcAddress,
    output logic                   commit,
    output logic                   inAck,
    output logic                   outValid,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retiredCount,
    output logic [2:0]             state
);

    localparam logic [2:0] FETCH    = 3'd0;
    localparam logic [2:0] EXEC     = 3'd1;
    localparam logic [2:0] WAIT_IN  = 3'd2;
    localparam logic [2:0] WAIT_OUT = 3'd3;
    localparam logic [2:0] HALTED   = 3'd4;

    logic [2:0]             next_state;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [COUNT_WIDTH-1:0] count;
    logic                   resume_q;
    logic                   resume_edge;
    logic                   branch_taken;
    logic                   commit_raw;
    logic                   in_ack_raw;
    logic                   out_valid_raw;

    assign resume_edge  = resume & ~resume_q;
    assign branch_taken = jump | (bzero & zeroFlag) | (bnegative & negativeFlag);

    always_comb begin
        next_state    = state;
        commit_raw    = 1'b0;
        in_ack_raw    = 1'b0;
        out_valid_raw = 1'b0;
        case (state)
            FETCH: next_state = EXEC;
            EXEC: begin
                if (HLT) begin
                    next_state = HALTED;
                end else if (isIn) begin
                    if (inputValid) begin
                        commit_raw = 1'b1;
                        in_ack_raw = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WAIT_IN;
                    end
                end else if (isOut) begin
                    out_valid_raw = 1'b1;
                    if (outputAck) begin
                        commit_raw = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WAIT_OUT;
                    end
                end else begin
                    commit_raw = 1'b1;
                    next_state = FETCH;
                end
            end
            WAIT_IN: begin
                if (inputValid) begin
                    commit_raw = 1'b1;
                    in_ack_raw = 1'b1;
                    next_state = FETCH;
                end
            end
            WAIT_OUT: begin
                out_valid_raw = 1'b1;
                if (outputAck) begin
                    commit_raw = 1'b1;
                    next_state = FETCH;
                end
            end
            HALTED: begin
                if (resume_edge) next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_ADDRESS;
            count    <= '0;
            resume_q <= 1'b0;
        end else begin
            state    <= next_state;
            resume_q <= resume;
            if (commit_raw) begin
                pc <= branch_taken ? mainAddress : pc + ADDR_WIDTH'(1);
            end else if (state == HALTED && resume_edge) begin
                pc <= pc + ADDR_WIDTH'(1);
            end
            if (commit_raw && count != '1) count <= count + COUNT_WIDTH'(1);
        end
    end

    // Strobes are forced low while reset is held so no write can slip through.
    assign commit       = commit_raw & ~reset;
    assign inAck        = in_ack_raw & ~reset;
    assign outValid     = out_valid_raw & ~reset;
    assign halted       = (state == HALTED);
    assign pcAddress    = pc;
    assign retiredCount = count;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed + randomized bench for instruction_sequencer with an
// instruction-level reference model (PC, retired count).
module tb_instruction_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        jump, bzero, bnegative, HLT, isIn, isOut;
    logic        zeroFlag, negativeFlag;
    logic [9:0]  mainAddress;
    logic        inputValid, outputAck, resume;
    logic [9:0]  pcAddress;
    logic        commit, inAck, outValid, halted;
    logic [3:0]  retiredCount;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    // model: PC and saturating 4-bit retired counter
    logic [9:0] m_pc;
    logic [3:0] m_cnt;

    instruction_sequencer #(.ADDR_WIDTH(10), .RESET_ADDRESS(10'd0), .COUNT_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .jump(jump), .bzero(bzero), .bnegative(bnegative),
        .HLT(HLT), .isIn(isIn), .isOut(isOut), .zeroFlag(zeroFlag),
        .negativeFlag(negativeFlag), .mainAddress(mainAddress), .inputValid(inputValid),
        .outputAck(outputAck), .resume(resume), .pcAddress(pcAddress), .commit(commit),
        .inAck(inAck), .outValid(outValid), .halted(halted), .retiredCount(retiredCount),
        .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        jump = 0; bzero = 0; bnegative = 0; HLT = 0; isIn = 0; isOut = 0;
        zeroFlag = 0; negativeFlag = 0; mainAddress = '0; inputValid = 0; outputAck = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_pc", 32'(pcAddress), 0);
        chk("rst_count", 32'(retiredCount), 0);
        chk("rst_commit", 32'(commit), 0);
        chk("rst_halted", 32'(halted), 0);
        reset = 0;
        m_pc  = '0;
        m_cnt = '0;
    endtask

    // One instruction: fetch cycle, exec cycle, then `stall` wait cycles for IN/OUT.
    task automatic do_instr(input logic j, input logic bz, input logic bn, input logic zf,
                            input logic nf, input logic in, input logic out,
                            input logic [9:0] tgt, input int stall);
        int st;
        st = (in || out) ? stall : 0;
        clear_inputs();
        jump = j; bzero = bz; bnegative = bn; zeroFlag = zf; negativeFlag = nf;
        isIn = in; isOut = out; mainAddress = tgt;
        #1;
        chk("fetch_state", 32'(state), 0);
        chk("fetch_pc", 32'(pcAddress), 32'(m_pc));
        chk("fetch_commit", 32'(commit), 0);
        chk("fetch_count", 32'(retiredCount), 32'(m_cnt));
        tick();
        for (int k = 0; k <= st; k++) begin
            inputValid = in && (k == st);
            outputAck  = !in && out && (k == st);
            #1;
            chk("ex_state", 32'(state), (k == 0) ? 1 : (in ? 2 : 3));
            chk("ex_pc", 32'(pcAddress), 32'(m_pc));
            chk("ex_commit", 32'(commit), 32'(k == st));
            chk("ex_inack", 32'(inAck), 32'(in && (k == st)));
            chk("ex_outvalid", 32'(outValid), 32'(!in && out));
            chk("ex_halted", 32'(halted), 0);
            tick();
        end
        if (j || (bz && zf) || (bn && nf)) m_pc = tgt;
        else m_pc = m_pc + 10'd1;
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    endtask

    task automatic plain();
        do_instr(0, 0, 0, 0, 0, 0, 0, 10'd0, 0);
    endtask

    task automatic jump_to(input logic [9:0] tgt);
        do_instr(1, 0, 0, 0, 0, 0, 0, tgt, 0);
    endtask

    // HLT: halted while resume is level-held; a fresh rising edge resumes at PC+1.
    task automatic do_halt(input logic hold);
        clear_inputs();
        HLT = 1;
        resume = hold;
        #1;
        chk("hfetch_state", 32'(state), 0);
        chk("hfetch_pc", 32'(pcAddress), 32'(m_pc));
        tick();
        chk("hexec_state", 32'(state), 1);
        chk("hexec_commit", 32'(commit), 0);
        tick();
        HLT = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("halt_state", 32'(state), 4);
            chk("halt_flag", 32'(halted), 1);
            chk("halt_commit", 32'(commit), 0);
            chk("halt_pc", 32'(pcAddress), 32'(m_pc));
            chk("halt_count", 32'(retiredCount), 32'(m_cnt));
            tick();
        end
        resume = 0;
        tick();
        chk("halt_low_state", 32'(state), 4);
        resume = 1;
        #1;
        chk("halt_edge_state", 32'(state), 4);
        tick();
        m_pc = m_pc + 10'd1;
    endtask

    initial begin
        clear_inputs();
        resume = 0;
        reset  = 1;
        m_pc   = '0;
        m_cnt  = '0;

        // reset state and three plain ops
        do_reset();
        plain(); plain(); plain();
        #1;
        chk("t1_pc", 32'(pcAddress), 3);
        chk("t1_count", 32'(retiredCount), 3);

        // PC wrap, jump, untaken/taken branches
        jump_to(10'd1023);
        plain();
        chk("t2_wrap", 32'(m_pc), 0);
        jump_to(10'd5);
        do_instr(1, 0, 0, 0, 0, 0, 0, 10'd200, 0);
        jump_to(10'd5);
        do_instr(0, 1, 0, 0, 0, 0, 0, 10'd200, 0);
        do_instr(0, 1, 0, 1, 0, 0, 0, 10'd300, 0);
        do_instr(0, 0, 1, 0, 1, 0, 0, 10'd77, 0);
        do_instr(0, 0, 1, 1, 0, 0, 0, 10'd99, 0);
        do_instr(1, 1, 1, 1, 1, 0, 0, 10'd42, 0);

        // IN stall, OUT stall, IN wins over OUT
        do_instr(0, 0, 0, 0, 0, 1, 0, 10'd0, 4);
        do_instr(0, 0, 0, 0, 0, 0, 1, 10'd0, 2);
        do_instr(0, 0, 0, 0, 0, 1, 1, 10'd0, 1);

        // HLT at PC=10 with resume held high
        jump_to(10'd10);
        resume = 1;
        do_halt(1'b1);
        #1;
        chk("t5_pc", 32'(pcAddress), 11);
        chk("t5_state", 32'(state), 0);

        // randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_halt(1'($urandom_range(0, 1)));
            end else begin
                do_instr(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                         1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                         1'($urandom_range(0, 3) == 0), 10'($urandom), int'($urandom_range(0, 3)));
            end
        end
        plain();

        // reset while waiting on OUT
        clear_inputs();
        isOut = 1;
        tick();
        tick();
        chk("t6_wait_state", 32'(state), 3);
        chk("t6_wait_outvalid", 32'(outValid), 1);
        reset = 1;
        #1;
        chk("t6_rst_outvalid", 32'(outValid), 0);
        tick();
        reset = 0;
        clear_inputs();
        #1;
        chk("t6_state", 32'(state), 0);
        chk("t6_pc", 32'(pcAddress), 0);
        chk("t6_outvalid", 32'(outValid), 0);
        chk("t6_count", 32'(retiredCount), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
